// File: rtl/zpu_irq_ctrl_if.sv
// Pipelined Wishbone register-bus bundle for the ZPU interrupt controller.
// The CPU data bus drives the master side; the controller is the slave.
`timescale 1ns/1ps
interface zpu_irq_ctrl_if;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    logic        wb_stall;

    modport master (
        output wb_adr, wb_dat_i, wb_sel, wb_cyc, wb_stb, wb_we,
        input  wb_dat_o, wb_ack, wb_stall
    );

    modport slave (
        input  wb_adr, wb_dat_i, wb_sel, wb_cyc, wb_stb, wb_we,
        output wb_dat_o, wb_ack, wb_stall
    );
endinterface

// File: rtl/zpu_irq_ctrl.sv
// ZPU interrupt controller: masks NUM_IRQ sources, requests the lowest pending one and tracks
// one in-service interrupt. Define IRQ_CTRL_EDGE_EN to add per-source rising-edge triggering.
`timescale 1ns/1ps
module zpu_irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int pc_bit_size = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IRQ-1:0]     irq_src,
    zpu_irq_ctrl_if.slave          wb,
    output logic                   cpu_irq,
    output logic [pc_bit_size-1:0] interuptadr,
    input  logic                   interrutack,
    input  logic                   exitint
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERV} state_t;

    state_t                   state_reg, state_next;
    logic                     cpu_irq_reg, cpu_irq_next;
    logic [pc_bit_size-1:0]   adr_reg, adr_next;
    logic [4:0]               req_id_reg, req_id_next;
    logic [4:0]               act_id_reg, act_id_next;
    logic                     in_svc_reg, in_svc_next;

    logic                     bus_acc, bus_wr;
    logic [5:0]               word;
    logic [31:0]              rd_data;
    logic                     ack_reg;
    logic [31:0]              dat_o_reg;

    logic [NUM_IRQ-1:0]       pending_reg, pending_next;
    logic [NUM_IRQ-1:0]       mask_reg;
    logic                     global_en_reg;
    logic [pc_bit_size-1:0]   vec_arr [NUM_IRQ];
    logic [NUM_IRQ-1:0]       vec_wr;

    logic                     unused_bits;

    assign bus_acc = wb.wb_cyc & wb.wb_stb;
    assign bus_wr  = bus_acc & wb.wb_we;
    assign word    = wb.wb_adr[7:2];

    // Byte lanes and address bits outside [7:2] carry no meaning for this block.
    assign unused_bits = ^{wb.wb_sel, wb.wb_adr[31:8], wb.wb_adr[1:0], wb.wb_dat_i};

    // One vector register per source, mapped at word 0x10 + index.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_vec
            logic [pc_bit_size-1:0] vec_reg;
            assign vec_wr[gi] = bus_wr & (word == 6'(16 + gi));
            always_ff @(posedge clk) begin
                if (rst) begin
                    vec_reg <= '0;
                end else if (vec_wr[gi]) begin
                    vec_reg <= wb.wb_dat_i[pc_bit_size-1:0];
                end
            end
            assign vec_arr[gi] = vec_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            global_en_reg <= 1'b0;
            mask_reg      <= '0;
        end else if (bus_wr && word == 6'd1) begin
            global_en_reg <= wb.wb_dat_i[31];
            mask_reg      <= wb.wb_dat_i[NUM_IRQ-1:0];
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_IRQ-1:0] edge_sel_reg, src_prev_reg;
    logic [NUM_IRQ-1:0] edge_rise, edge_clr, ack_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_sel_reg <= '0;
            src_prev_reg <= '0;
        end else begin
            src_prev_reg <= irq_src;
            if (bus_wr && word == 6'd3) begin
                edge_sel_reg <= wb.wb_dat_i[NUM_IRQ-1:0];
            end
        end
    end

    assign edge_rise = irq_src & ~src_prev_reg;
    assign edge_clr  = ((bus_wr && word == 6'd0) ? wb.wb_dat_i[NUM_IRQ-1:0] : '0) | ack_clr;

    // A new edge in the same cycle as a clear keeps the source pending.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
            assign ack_clr[gi] = (state_reg == ST_REQ) & interrutack & (req_id_reg == 5'(gi));
            assign pending_next[gi] = edge_sel_reg[gi]
                ? (edge_rise[gi] | (pending_reg[gi] & ~edge_clr[gi]))
                : irq_src[gi];
        end
    endgenerate
`else
    assign pending_next = irq_src;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    logic [NUM_IRQ-1:0]     req_bits;
    logic                   found;
    logic [4:0]             pick_id;
    logic [pc_bit_size-1:0] pick_vec;

    assign req_bits = pending_reg & mask_reg & {NUM_IRQ{global_en_reg}};

    // Scan from the top so the lowest requesting index is the last one to win.
    always_comb begin
        found    = 1'b0;
        pick_id  = '0;
        pick_vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_bits[i]) begin
                found    = 1'b1;
                pick_id  = 5'(i);
                pick_vec = vec_arr[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cpu_irq_next = cpu_irq_reg;
        adr_next     = adr_reg;
        req_id_next  = req_id_reg;
        act_id_next  = act_id_reg;
        in_svc_next  = in_svc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    cpu_irq_next = 1'b1;
                    adr_next     = pick_vec;
                    req_id_next  = pick_id;
                    state_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (interrutack) begin
                    cpu_irq_next = 1'b0;
                    act_id_next  = req_id_reg;
                    in_svc_next  = 1'b1;
                    state_next   = ST_SERV;
                end
            end
            ST_SERV: begin
                if (exitint) begin
                    in_svc_next = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cpu_irq_reg <= 1'b0;
            adr_reg     <= '0;
            req_id_reg  <= '0;
            act_id_reg  <= '0;
            in_svc_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cpu_irq_reg <= cpu_irq_next;
            adr_reg     <= adr_next;
            req_id_reg  <= req_id_next;
            act_id_reg  <= act_id_next;
            in_svc_reg  <= in_svc_next;
        end
    end

    always_comb begin
        rd_data = '0;
        case (word)
            6'd0: rd_data[NUM_IRQ-1:0] = pending_reg;
            6'd1: begin
                rd_data[31]          = global_en_reg;
                rd_data[NUM_IRQ-1:0] = mask_reg;
            end
            6'd2: begin
                rd_data[31]  = in_svc_reg;
                rd_data[4:0] = act_id_reg;
            end
`ifdef IRQ_CTRL_EDGE_EN
            6'd3: rd_data[NUM_IRQ-1:0] = edge_sel_reg;
`endif
            default: begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (word == 6'(16 + i)) begin
                        rd_data[pc_bit_size-1:0] = vec_arr[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg   <= 1'b0;
            dat_o_reg <= '0;
        end else begin
            ack_reg   <= bus_acc;
            dat_o_reg <= (bus_acc && !wb.wb_we) ? rd_data : '0;
        end
    end

    assign wb.wb_ack    = ack_reg;
    assign wb.wb_dat_o  = dat_o_reg;
    assign wb.wb_stall  = 1'b0;
    assign cpu_irq      = cpu_irq_reg;
    assign interuptadr  = adr_reg;

endmodule
